// File: rtl/mem_access_stage_pkg.sv
// Shared definitions for the MEM stage: memory op codes, FSM states and
// small op-classification helpers used by the stage and its lane aligner.
package mem_access_stage_pkg;

  localparam logic [3:0] MEM_NOP = 4'd0;
  localparam logic [3:0] MEM_LB  = 4'd1;
  localparam logic [3:0] MEM_LBU = 4'd2;
  localparam logic [3:0] MEM_LH  = 4'd3;
  localparam logic [3:0] MEM_LHU = 4'd4;
  localparam logic [3:0] MEM_LW  = 4'd5;
  localparam logic [3:0] MEM_SB  = 4'd6;
  localparam logic [3:0] MEM_SH  = 4'd7;
  localparam logic [3:0] MEM_SW  = 4'd8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  function automatic logic isLoadOp(input logic [3:0] op);
    return (op >= MEM_LB) && (op <= MEM_LW);
  endfunction

  function automatic logic isStoreOp(input logic [3:0] op);
    return (op >= MEM_SB) && (op <= MEM_SW);
  endfunction

  // Halfwords need a[0]==0, words need a[1:0]==0; bytes are always aligned.
  function automatic logic isMisaligned(input logic [3:0] op, input logic [1:0] a);
    case (op)
      MEM_LH, MEM_LHU, MEM_SH: return a[0];
      MEM_LW, MEM_SW:          return a != 2'b00;
      default:                 return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_stage_if.sv
// Request/acknowledge data bus between the MEM stage (master) and memory (slave).
interface mem_bus_if;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ack;

  modport master (
    output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    input  bus_rdata, bus_ack
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    output bus_rdata, bus_ack
  );
endinterface

// File: rtl/mem_access_stage_lane_align.sv
// Combinational byte-lane handling: store byte enables and replicated write
// data, plus selection and sign/zero extension of the loaded lane.
module mem_lane_align
  import mem_access_stage_pkg::*;
(
  input  logic [3:0]  i_ramOp,
  input  logic [1:0]  i_addrLo,
  input  logic [31:0] i_storeData,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic [31:0] o_loadData
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = i_rdata[{i_addrLo, 3'b000} +: 8];
  assign w_half = i_addrLo[1] ? i_rdata[31:16] : i_rdata[15:0];

  always_comb begin
    o_be    = 4'hF;
    o_wdata = i_storeData;
    case (i_ramOp)
      MEM_SB: begin
        o_be    = 4'b0001 << i_addrLo;
        o_wdata = {4{i_storeData[7:0]}};
      end
      MEM_SH: begin
        o_be    = 4'b0011 << {i_addrLo[1], 1'b0};
        o_wdata = {2{i_storeData[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    o_loadData = i_rdata;
    case (i_ramOp)
      MEM_LB:  o_loadData = {{24{w_byte[7]}}, w_byte};
      MEM_LBU: o_loadData = {24'd0, w_byte};
      MEM_LH:  o_loadData = {{16{w_half[15]}}, w_half};
      MEM_LHU: o_loadData = {16'd0, w_half};
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: issues loads/stores over the req/ack bus, stalls the
// front of the pipe while the access is outstanding, and reports faults.
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  ramOp_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] storeData_i,
  input  logic [31:0] aluData_i,
  input  logic [4:0]  writeAddr_i,
  input  logic        writeEnable_i,
  mem_bus_if.master   bus,
  output logic [31:0] wbData_o,
  output logic [4:0]  writeAddr_o,
  output logic        writeEnable_o,
  output logic        stall_req,
  output logic        adel_o,
  output logic        ades_o,
  output logic        busErr_o
);

  state_e           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [31:0]      r_rdata;
  logic             r_busErr;
  logic             r_busReq;
  logic             r_busWe;
  logic [31:0]      r_busAddr;
  logic [3:0]       r_busBe;
  logic [31:0]      r_busWdata;

  logic        w_isLoad;
  logic        w_isStore;
  logic        w_memOp;
  logic        w_misaligned;
  logic        w_inIdle;
  logic        w_issue;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [31:0] w_loadData;

  assign w_isLoad     = isLoadOp(ramOp_i);
  assign w_isStore    = isStoreOp(ramOp_i);
  assign w_memOp      = w_isLoad | w_isStore;
  assign w_misaligned = w_memOp & isMisaligned(ramOp_i, addr_i[1:0]);
  assign w_inIdle     = (r_state == S_IDLE);
  assign w_issue      = w_inIdle & w_memOp & ~w_misaligned;

  // EX_MEM stays frozen until DONE, so the live op/address are still valid
  // for load extension when the captured data is presented.
  mem_lane_align u_align (
    .i_ramOp     (ramOp_i),
    .i_addrLo    (addr_i[1:0]),
    .i_storeData (storeData_i),
    .i_rdata     (r_rdata),
    .o_be        (w_be),
    .o_wdata     (w_wdata),
    .o_loadData  (w_loadData)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_rdata    <= '0;
      r_busErr   <= 1'b0;
      r_busReq   <= 1'b0;
      r_busWe    <= 1'b0;
      r_busAddr  <= '0;
      r_busBe    <= '0;
      r_busWdata <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_issue) begin
            r_state    <= S_REQ;
            r_cnt      <= '0;
            r_busErr   <= 1'b0;
            r_busReq   <= 1'b1;
            r_busWe    <= w_isStore;
            r_busAddr  <= {addr_i[31:2], 2'b00};
            r_busBe    <= w_be;
            r_busWdata <= w_wdata;
          end
        end
        S_REQ: begin
          // An ack in the final allowed cycle wins over the timeout.
          if (bus.bus_ack) begin
            r_rdata  <= bus.bus_rdata;
            r_busReq <= 1'b0;
            r_state  <= S_DONE;
          end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
            r_busReq <= 1'b0;
            r_busErr <= 1'b1;
            r_state  <= S_DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DONE: begin
          r_busErr <= 1'b0;
          r_state  <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.bus_req   = r_busReq;
  assign bus.bus_we    = r_busWe;
  assign bus.bus_addr  = r_busAddr;
  assign bus.bus_be    = r_busBe;
  assign bus.bus_wdata = r_busWdata;

  assign stall_req     = w_issue | (r_state == S_REQ);
  assign adel_o        = w_inIdle & w_misaligned & w_isLoad;
  assign ades_o        = w_inIdle & w_misaligned & w_isStore;
  assign busErr_o      = (r_state == S_DONE) & r_busErr;
  assign wbData_o      = ((r_state == S_DONE) && w_isLoad) ? w_loadData : aluData_i;
  assign writeAddr_o   = writeAddr_i;
  assign writeEnable_o = writeEnable_i & ~stall_req & ~(w_inIdle & w_misaligned) & ~busErr_o;

endmodule
